// File: rtl/t01_ai_move_executor.sv
// t01_ai_move_executor: drives rotate/shift/drop commands until the falling piece reaches a chosen placement.
// Define T01_AI_MOVE_TIMEOUT_EN to enable the cmd_ack watchdog (ACK_TIMEOUT cycles).
module t01_ai_move_executor #(
    parameter int GAP         = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [1:0] target_rot_i,
    input  logic [3:0] target_x_i,
    input  logic [1:0] piece_rot_i,
    input  logic [3:0] piece_x_i,
    input  logic       cmd_ack_i,
    output logic       cmd_rotate_o,
    output logic       cmd_left_o,
    output logic       cmd_right_o,
    output logic       cmd_drop_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);
    typedef enum logic [2:0] {IDLE, ROTATE, SHIFT, DROP, GAP_WAIT, FINISH} state_t;
    state_t     state_q, ret_q;
    logic [1:0] tgt_rot_q;
    logic [3:0] tgt_x_q, issue_x_q, sh_cnt_q;
    logic [2:0] rot_cnt_q, gap_cnt_q;
    logic       chk_q, rot_q, left_q, right_q, drop_q, done_q, err_q;
`ifdef T01_AI_MOVE_TIMEOUT_EN
    logic [7:0] wd_q;
`endif
    logic       any_cmd_d, rot_need_d, rot_err_d, sh_err_d, sh_drop_d, sh_left_d, sh_right_d;

    // Shift decision is shared so a settled rotation can fall straight through to it.
    always_comb begin
        any_cmd_d  = rot_q | left_q | right_q | drop_q;
        rot_need_d = piece_rot_i != tgt_rot_q;
        rot_err_d  = rot_need_d && rot_cnt_q == 3'd3;
        sh_err_d   = piece_x_i != tgt_x_q && ((chk_q && piece_x_i == issue_x_q) || sh_cnt_q == 4'd10);
        sh_drop_d  = piece_x_i == tgt_x_q || sh_err_d;
        sh_left_d  = !sh_drop_d && piece_x_i > tgt_x_q;
        sh_right_d = !sh_drop_d && piece_x_i < tgt_x_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ret_q     <= ROTATE;
            tgt_rot_q <= '0;
            tgt_x_q   <= '0;
            issue_x_q <= '0;
            sh_cnt_q  <= '0;
            rot_cnt_q <= '0;
            gap_cnt_q <= '0;
            chk_q     <= 1'b0;
            rot_q     <= 1'b0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            drop_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef T01_AI_MOVE_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    tgt_rot_q <= target_rot_i;
                    tgt_x_q   <= target_x_i > 4'd9 ? 4'd9 : target_x_i;
                    err_q     <= 1'b0;
                    rot_cnt_q <= '0;
                    sh_cnt_q  <= '0;
                    chk_q     <= 1'b0;
                    state_q   <= ROTATE;
                end
                ROTATE, SHIFT: begin
                    if (any_cmd_d) begin
                        if (cmd_ack_i) begin
                            rot_q     <= 1'b0;
                            left_q    <= 1'b0;
                            right_q   <= 1'b0;
                            gap_cnt_q <= '0;
                            ret_q     <= state_q;
                            state_q   <= GAP_WAIT;
                            if (rot_q) rot_cnt_q <= rot_cnt_q + 3'd1;
                            else sh_cnt_q <= sh_cnt_q + 4'd1;
                        end
                    end else if (state_q == ROTATE && rot_need_d && !rot_err_d) begin
                        rot_q <= 1'b1;
                    end else begin
                        if (state_q == ROTATE && rot_err_d) err_q <= 1'b1;
                        if (sh_drop_d) begin
                            drop_q  <= 1'b1;
                            state_q <= DROP;
                            if (sh_err_d) err_q <= 1'b1;
                        end else begin
                            left_q    <= sh_left_d;
                            right_q   <= sh_right_d;
                            issue_x_q <= piece_x_i;
                            chk_q     <= 1'b1;
                            state_q   <= SHIFT;
                        end
                    end
                end
                DROP: if (cmd_ack_i) begin
                    drop_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= FINISH;
                end
                GAP_WAIT: begin
                    if (gap_cnt_q == 3'(GAP - 1)) state_q <= ret_q;
                    else gap_cnt_q <= gap_cnt_q + 3'd1;
                end
                FINISH: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
`ifdef T01_AI_MOVE_TIMEOUT_EN
            // Watchdog overrides the normal transition when the game never acknowledges.
            if (any_cmd_d && !cmd_ack_i) begin
                if (wd_q == 8'(ACK_TIMEOUT - 1)) begin
                    rot_q   <= 1'b0;
                    left_q  <= 1'b0;
                    right_q <= 1'b0;
                    drop_q  <= 1'b0;
                    err_q   <= 1'b1;
                    done_q  <= 1'b1;
                    wd_q    <= '0;
                    state_q <= FINISH;
                end else begin
                    wd_q <= wd_q + 8'd1;
                end
            end else begin
                wd_q <= '0;
            end
`endif
        end
    end

    assign cmd_rotate_o = rot_q;
    assign cmd_left_o   = left_q;
    assign cmd_right_o  = right_q;
    assign cmd_drop_o   = drop_q;
    assign busy_o       = state_q != IDLE;
    assign done_o       = done_q;
    assign error_o      = err_q;
endmodule

// File: tb/tb_t01_ai_move_executor.sv
// tb_t01_ai_move_executor: table-driven placement runs against a small game model, plus reset/latency/start-ignore sequences.
module tb_t01_ai_move_executor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] target_rot = '0;
    logic [3:0] target_x = '0;
    logic [1:0] prot = '0;
    logic [3:0] px = '0;
    logic       ack = 1'b0;
    logic       cmd_rotate, cmd_left, cmd_right, cmd_drop, busy, done, error;

    int checks = 0, errors = 0;
    int n_rot, n_left, n_right, n_drop, n_done, onehot_bad;
    logic       rot_blk;
    logic [3:0] wall_l, wall_r;

    t01_ai_move_executor #(.GAP(2), .ACK_TIMEOUT(5)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .target_rot_i(target_rot),
        .target_x_i(target_x), .piece_rot_i(prot), .piece_x_i(px), .cmd_ack_i(ack),
        .cmd_rotate_o(cmd_rotate), .cmd_left_o(cmd_left), .cmd_right_o(cmd_right),
        .cmd_drop_o(cmd_drop), .busy_o(busy), .done_o(done), .error_o(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] trot;
        logic [3:0] tx;
        logic [1:0] prot0;
        logic [3:0] px0;
        logic       rblk;
        logic [3:0] wl;
        logic [3:0] wr;
        int         e_rot;
        int         e_left;
        int         e_right;
        logic       e_err;
        logic [3:0] e_px;
        logic [1:0] e_prot;
    } vec_t;
    vec_t v[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Game model: acknowledged moves update the piece 1 time unit after the edge the DUT sampled.
    task automatic tick();
        logic r, l, rt, d;
        r  = cmd_rotate & ack;
        l  = cmd_left & ack;
        rt = cmd_right & ack;
        d  = cmd_drop & ack;
        if ((32'(cmd_rotate) + 32'(cmd_left) + 32'(cmd_right) + 32'(cmd_drop)) > 1) onehot_bad++;
        @(posedge clk);
        #1;
        if (r) begin n_rot++; if (!rot_blk) prot = prot + 2'd1; end
        if (l) begin n_left++; if (px > wall_l) px = px - 4'd1; end
        if (rt) begin n_right++; if (px < wall_r) px = px + 4'd1; end
        if (d) n_drop++;
        if (done) n_done++;
    endtask

    task automatic clear_counts();
        n_rot = 0; n_left = 0; n_right = 0; n_drop = 0; n_done = 0;
    endtask

    task automatic wait_idle(input string name);
        bit fin = 0;
        for (int k = 0; k < 400 && !fin; k++) begin
            tick();
            if (n_done > 0 && !busy) fin = 1;
        end
        check({name, "_finished"}, 32'(fin), 32'd1);
    endtask

    initial begin
        onehot_bad = 0;
        rot_blk = 0; wall_l = 0; wall_r = 9;
        clear_counts();
        v[0] = '{2'd2, 4'd7,  2'd0, 4'd4,  1'b0, 4'd0, 4'd9,  2, 0, 3, 1'b0, 4'd7, 2'd2};
        v[1] = '{2'd0, 4'd12, 2'd0, 4'd9,  1'b0, 4'd0, 4'd9,  0, 0, 0, 1'b0, 4'd9, 2'd0};
        v[2] = '{2'd0, 4'd0,  2'd0, 4'd1,  1'b0, 4'd1, 4'd9,  0, 1, 0, 1'b1, 4'd1, 2'd0};
        v[3] = '{2'd3, 4'd2,  2'd1, 4'd5,  1'b0, 4'd0, 4'd9,  2, 3, 0, 1'b0, 4'd2, 2'd3};
        v[4] = '{2'd1, 4'd5,  2'd2, 4'd5,  1'b0, 4'd0, 4'd9,  3, 0, 0, 1'b0, 4'd5, 2'd1};
        v[5] = '{2'd0, 4'd3,  2'd1, 4'd3,  1'b1, 4'd0, 4'd9,  3, 0, 0, 1'b1, 4'd3, 2'd1};
        v[6] = '{2'd0, 4'd9,  2'd0, 4'd7,  1'b0, 4'd0, 4'd8,  0, 0, 2, 1'b1, 4'd8, 2'd0};
        v[7] = '{2'd0, 4'd0,  2'd0, 4'd15, 1'b0, 4'd0, 4'd15, 0, 10, 0, 1'b1, 4'd5, 2'd0};

        #3;
        check("reset_outputs", 32'({cmd_rotate, cmd_left, cmd_right, cmd_drop, busy, done, error}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;

        ack = 1;
        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            rot_blk = v[i].rblk; wall_l = v[i].wl; wall_r = v[i].wr;
            prot = v[i].prot0; px = v[i].px0;
            target_rot = v[i].trot; target_x = v[i].tx;
            clear_counts();
            start = 1;
            tick();
            start = 0;
            wait_idle(tag);
            check({tag, "_rotates"}, 32'(n_rot), 32'(v[i].e_rot));
            check({tag, "_lefts"}, 32'(n_left), 32'(v[i].e_left));
            check({tag, "_rights"}, 32'(n_right), 32'(v[i].e_right));
            check({tag, "_drops"}, 32'(n_drop), 32'd1);
            check({tag, "_dones"}, 32'(n_done), 32'd1);
            check({tag, "_error"}, 32'(error), 32'(v[i].e_err));
            check({tag, "_piece_x"}, 32'(px), 32'(v[i].e_px));
            check({tag, "_piece_rot"}, 32'(prot), 32'(v[i].e_prot));
        end
        rot_blk = 0; wall_l = 0; wall_r = 9;

        // Minimum latency: drop visible after the first edge past the start edge, done after the next.
        prot = 1; px = 5; target_rot = 1; target_x = 5; clear_counts();
        start = 1;
        tick();
        start = 0;
        check("lat_busy_c0", 32'(busy), 32'd1);
        check("lat_drop_c0", 32'(cmd_drop), 32'd0);
        tick();
        check("lat_drop_c1", 32'(cmd_drop), 32'd1);
        tick();
        check("lat_done_c2", 32'({done, cmd_drop}), 32'b10);
        tick();
        check("lat_idle_c3", 32'({done, busy}), 32'b00);

        // Start re-pulsed mid-shift with other targets is ignored.
        prot = 0; px = 2; target_rot = 0; target_x = 8; clear_counts();
        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 4; k++) tick();
        check("restart_in_shift", 32'(busy), 32'd1);
        target_rot = 3; target_x = 0; start = 1;
        tick();
        start = 0;
        wait_idle("restart");
        check("restart_piece_x", 32'(px), 32'd8);
        check("restart_rotates", 32'(n_rot), 32'd0);
        check("restart_rights", 32'(n_right), 32'd6);
        check("restart_error", 32'(error), 32'd0);

        // Reset while cmd_right is held without ack.
        ack = 0; prot = 0; px = 2; target_rot = 0; target_x = 5; clear_counts();
        start = 1;
        tick();
        start = 0;
        tick();
        check("hold_right", 32'(cmd_right), 32'd1);
        tick(); tick();
        check("hold_right_still", 32'(cmd_right), 32'd1);
        #2 rst_n = 0;
        #1 check("midop_reset_outputs", 32'({cmd_rotate, cmd_left, cmd_right, cmd_drop, busy, done, error}), 32'd0);
        tick(); tick();
        rst_n = 1;
        check("reset_release_idle", 32'(busy), 32'd0);
        check("reset_no_done", 32'(n_done), 32'd0);
        ack = 1;
        start = 1;
        tick();
        start = 0;
        check("first_start_accepted", 32'(busy), 32'd1);
        wait_idle("post_reset");
        check("post_reset_piece_x", 32'(px), 32'd5);
        check("post_reset_error", 32'(error), 32'd0);

`ifdef T01_AI_MOVE_TIMEOUT_EN
        ack = 0; prot = 0; px = 3; target_rot = 1; target_x = 3; clear_counts();
        start = 1;
        tick();
        start = 0;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("wd_rotate_held", 32'(cmd_rotate), 32'd1);
            tick();
        end
        check("wd_rotate_held_last", 32'(cmd_rotate), 32'd1);
        tick();
        check("wd_rotate_dropped", 32'({cmd_rotate, done, error}), 32'b011);
        tick();
        check("wd_idle", 32'({busy, done}), 32'b00);
`else
        ack = 0; prot = 0; px = 3; target_rot = 1; target_x = 3; clear_counts();
        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 22; k++) tick();
        check("noack_rotate_held", 32'(cmd_rotate), 32'd1);
        check("noack_no_done", 32'(n_done), 32'd0);
        #2 rst_n = 0;
        #1 check("noack_reset", 32'({cmd_rotate, busy}), 32'd0);
        tick();
        rst_n = 1;
`endif
        check("one_hot_commands", 32'(onehot_bad), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
